// File: rtl/lane_serdes_align_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lane_serdes_align_pkg
//  Description : Shared serdes definitions. Contains the symbol width, the
//                comma codes, the lane aligner state type and a bit-reversal
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package lane_serdes_align_pkg;

    localparam int unsigned SYM_W = 10;

    // K28.5 in both running disparities, bit 0 is the first bit on the wire
    localparam logic [SYM_W-1:0] NCOMMA = 10'h17C;
    localparam logic [SYM_W-1:0] PCOMMA = 10'h283;

    typedef logic [0:0] lane_state_t;
    localparam lane_state_t ST_HUNT   = 1'b0;
    localparam lane_state_t ST_LOCKED = 1'b1;

    function automatic logic [SYM_W-1:0] sym_reverse(input logic [SYM_W-1:0] s);
        logic [SYM_W-1:0] r;
        for (int k = 0; k < int'(SYM_W); k++) begin
            r[k] = s[SYM_W-1-k];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_serdes_align_if.sv
`default_nettype none
// ============================================================================
//  Module      : lane_serdes_align_if
//  Description : Parallel/serial bundle of the lane serdes. The Loopback
//                control only exists when SERDES_LOOPBACK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lane_serdes_align_if #(
    parameter int Width = 16
);
    import lane_serdes_align_pkg::*;

    logic                     BitReverse;
    logic [Width*SYM_W-1:0]   ParInVec;
    logic                     ParLoad;
    logic [Width-1:0]         SerOut;
    logic [Width-1:0]         SerIn;
    logic [Width*SYM_W-1:0]   ParOut;
    logic [Width-1:0]         ParValid;
    logic [Width-1:0]         Locked;
`ifdef SERDES_LOOPBACK_EN
    logic                     Loopback;

    modport master (
        output BitReverse, ParInVec, SerIn, Loopback,
        input  ParLoad, SerOut, ParOut, ParValid, Locked
    );
    modport slave (
        input  BitReverse, ParInVec, SerIn, Loopback,
        output ParLoad, SerOut, ParOut, ParValid, Locked
    );
`else
    modport master (
        output BitReverse, ParInVec, SerIn,
        input  ParLoad, SerOut, ParOut, ParValid, Locked
    );
    modport slave (
        input  BitReverse, ParInVec, SerIn,
        output ParLoad, SerOut, ParOut, ParValid, Locked
    );
`endif

endinterface
`default_nettype wire

// File: rtl/lane_serdes_align_rx.sv
`default_nettype none
// ============================================================================
//  Module      : lane_rx_align
//  Description : Single-lane receive aligner. Slides a 10-bit window over the
//                serial input, locks onto commas, delivers one symbol every
//                ten bits, realigns on repeated off-boundary commas and
//                drops lock when commas stop arriving.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_rx_align
    import lane_serdes_align_pkg::*;
#(
    parameter int MisalignLimit = 2,
    parameter int CommaTimeout  = 1024
)(
    input  wire               clk,
    input  wire               rst,
    input  wire               i_bit,
    input  wire               i_bit_rev,
    output logic [SYM_W-1:0]  o_sym,
    output logic              o_valid,
    output logic              o_locked
);

    localparam logic [3:0]  c_mis_limit = 4'(MisalignLimit);
    localparam logic [15:0] c_tmo_limit = 16'(CommaTimeout);

    logic [SYM_W-1:0] r_win;
    logic [SYM_W-1:0] r_sym;
    logic             r_valid;
    lane_state_t      r_state;
    logic [3:0]       r_phase;
    logic [3:0]       r_mis;
    logic [15:0]      r_tmo;

    logic [SYM_W-1:0] w_view;
    logic             w_comma;
    logic             w_boundary;
    logic [3:0]       w_mis_nxt;
    logic [15:0]      w_tmo_nxt;

    // Comparison and delivery both use the window as the user sees it
    assign w_view     = i_bit_rev ? sym_reverse(r_win) : r_win;
    assign w_comma    = (w_view == NCOMMA) || (w_view == PCOMMA);
    assign w_boundary = (r_phase == 4'd9);
    assign w_mis_nxt  = r_mis + 4'd1;
    assign w_tmo_nxt  = r_tmo + 16'd1;

    // Receive window: newest bit enters at the msb so bit 0 is the oldest
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win <= '0;
        end else begin
            r_win <= {i_bit, r_win[SYM_W-1:1]};
        end
    end

    // Hunt/lock state machine with symbol delivery
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HUNT;
            r_sym   <= '0;
            r_valid <= 1'b0;
            r_phase <= '0;
            r_mis   <= '0;
            r_tmo   <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_HUNT: begin
                    r_sym   <= '0;
                    r_phase <= '0;
                    r_mis   <= '0;
                    r_tmo   <= '0;
                    if (w_comma) begin
                        r_sym   <= w_view;
                        r_valid <= 1'b1;
                        r_state <= ST_LOCKED;
                    end
                end
                default: begin
                    r_phase <= w_boundary ? 4'd0 : r_phase + 4'd1;
                    // Realignment is checked first so it beats a timeout
                    if (w_comma && !w_boundary) begin
                        if (w_mis_nxt == c_mis_limit) begin
                            r_sym   <= w_view;
                            r_valid <= 1'b1;
                            r_phase <= '0;
                            r_mis   <= '0;
                            r_tmo   <= '0;
                        end else begin
                            r_mis <= w_mis_nxt;
                        end
                    end else if (w_boundary) begin
                        if (w_comma) begin
                            r_sym   <= w_view;
                            r_valid <= 1'b1;
                            r_mis   <= '0;
                            r_tmo   <= '0;
                        end else if (w_tmo_nxt == c_tmo_limit) begin
                            // Lost the comma stream: output goes quiet at once
                            r_state <= ST_HUNT;
                            r_sym   <= '0;
                            r_mis   <= '0;
                            r_tmo   <= '0;
                        end else begin
                            r_sym   <= w_view;
                            r_valid <= 1'b1;
                            r_tmo   <= w_tmo_nxt;
                        end
                    end
                end
            endcase
        end
    end

    assign o_sym    = r_sym;
    assign o_valid  = r_valid;
    assign o_locked = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: rtl/lane_serdes_align.sv
`default_nettype none
// ============================================================================
//  Module      : lane_serdes_align
//  Description : Multi-lane 10-bit serializer plus per-lane comma aligning
//                deserializer. Define SERDES_LOOPBACK_EN to add the Loopback
//                control that feeds each lane's transmit bit to its receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_serdes_align
    import lane_serdes_align_pkg::*;
#(
    parameter int Width         = 16,
    parameter int MisalignLimit = 2,
    parameter int CommaTimeout  = 1024
)(
    input  wire                 SerClk,
    input  wire                 Reset,
    lane_serdes_align_if.slave  io
);

    logic [3:0]             r_tx_cnt;
    logic                   w_par_load;
    logic [Width-1:0]       w_ser_out;
    logic [Width*SYM_W-1:0] w_par_out;
    logic [Width-1:0]       w_par_valid;
    logic [Width-1:0]       w_locked;

    assign w_par_load = (r_tx_cnt == 4'd9);

    // Symbol bit counter shared by all transmit lanes
    always_ff @(posedge SerClk) begin
        if (Reset || w_par_load) begin
            r_tx_cnt <= '0;
        end else begin
            r_tx_cnt <= r_tx_cnt + 4'd1;
        end
    end

    for (genvar i = 0; i < Width; i++) begin : g_lane
        logic [SYM_W-1:0] r_tx_sh;
        logic [SYM_W-1:0] w_tx_sym;
        logic             w_rx_bit;

        assign w_tx_sym = io.BitReverse ? sym_reverse(io.ParInVec[i*SYM_W +: SYM_W])
                                        : io.ParInVec[i*SYM_W +: SYM_W];

        // Transmit shifter: parallel load once per symbol, lsb goes out first
        always_ff @(posedge SerClk) begin
            if (Reset) begin
                r_tx_sh <= '0;
            end else if (w_par_load) begin
                r_tx_sh <= w_tx_sym;
            end else begin
                r_tx_sh <= {1'b0, r_tx_sh[SYM_W-1:1]};
            end
        end

        assign w_ser_out[i] = r_tx_sh[0];

`ifdef SERDES_LOOPBACK_EN
        assign w_rx_bit = io.Loopback ? w_ser_out[i] : io.SerIn[i];
`else
        assign w_rx_bit = io.SerIn[i];
`endif

        lane_rx_align #(
            .MisalignLimit (MisalignLimit),
            .CommaTimeout  (CommaTimeout)
        ) u_rx (
            .clk       (SerClk),
            .rst       (Reset),
            .i_bit     (w_rx_bit),
            .i_bit_rev (io.BitReverse),
            .o_sym     (w_par_out[i*SYM_W +: SYM_W]),
            .o_valid   (w_par_valid[i]),
            .o_locked  (w_locked[i])
        );
    end

    assign io.ParLoad  = w_par_load;
    assign io.SerOut   = w_ser_out;
    assign io.ParOut   = w_par_out;
    assign io.ParValid = w_par_valid;
    assign io.Locked   = w_locked;

endmodule
`default_nettype wire

// File: tb/tb_lane_serdes_align.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lane_serdes_align
//  Description : Self-checking bench for lane_serdes_align: transmit timing
//                table plus receive lock, realign, timeout, bit-reverse,
//                mid-symbol reset and (with SERDES_LOOPBACK_EN) loopback.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_serdes_align;

    localparam int W = 4;
    localparam logic [9:0] K_N      = 10'h17C;
    localparam logic [9:0] K_P      = 10'h283;
    localparam logic [9:0] D_AA     = 10'h0AA;
    localparam logic [9:0] K_N_REV  = 10'h0FA;
    localparam logic [9:0] D_AA_REV = 10'h154;

    logic SerClk = 1'b0;
    logic Reset  = 1'b1;
    always #5 SerClk = ~SerClk;

    lane_serdes_align_if #(.Width(W)) bus();

    lane_serdes_align #(
        .Width         (W),
        .MisalignLimit (2),
        .CommaTimeout  (4)
    ) dut (
        .SerClk (SerClk),
        .Reset  (Reset),
        .io     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-edge record of lane 0 receive outputs
    logic       rec_valid [256];
    logic [9:0] rec_par   [256];
    logic       rec_lock  [256];
    bit         q_bits[$];

    task automatic push_sym(input logic [9:0] s);
        for (int b = 0; b < 10; b++) q_bits.push_back(s[b]);
    endtask

    task automatic push_zeros(input int n);
        for (int b = 0; b < n; b++) q_bits.push_back(1'b0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        bus.SerIn = '0;
        repeat (3) @(posedge SerClk);
        @(negedge SerClk);
        Reset = 1'b0;
    endtask

    task automatic run_q();
        int n;
        n = q_bits.size();
        for (int k = 0; k < 256; k++) begin
            rec_valid[k] = 1'b0;
            rec_par[k]   = '0;
            rec_lock[k]  = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            bus.SerIn[0] = q_bits[k];
            @(posedge SerClk);
            #1;
            rec_valid[k] = bus.ParValid[0];
            rec_par[k]   = bus.ParOut[9:0];
            rec_lock[k]  = bus.Locked[0];
            @(negedge SerClk);
        end
        q_bits.delete();
    endtask

    function automatic int count_valid(input int lo, input int hi);
        int c = 0;
        for (int k = lo; k <= hi; k++) if (rec_valid[k]) c++;
        return c;
    endfunction

    function automatic int count_lock(input int lo, input int hi);
        int c = 0;
        for (int k = lo; k <= hi; k++) if (rec_lock[k]) c++;
        return c;
    endfunction

    typedef struct {
        logic         brev;
        int           cyc;
        logic         exp_load;
        logic [W-1:0] exp_ser;
    } tx_vec_t;

    tx_vec_t tv[60];

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:9] seq_fwd;
        logic [0:9] seq_rev;
        logic [0:9] seq;
        logic       b;

        bus.BitReverse = 1'b0;
        bus.ParInVec   = {W{K_N}};
        bus.SerIn      = '0;
`ifdef SERDES_LOOPBACK_EN
        bus.Loopback   = 1'b0;
`endif

        // Wire order of 10'h17C, and of its bit reversal
        seq_fwd = 10'b0011111010;
        seq_rev = 10'b0101111100;
        for (int k = 0; k < 60; k++) begin
            tv[k].brev     = (k >= 30);
            tv[k].cyc      = k % 30;
            tv[k].exp_load = ((k % 10) == 9);
            seq = tv[k].brev ? seq_rev : seq_fwd;
            b   = seq[(tv[k].cyc) % 10];
            tv[k].exp_ser  = (tv[k].cyc < 10) ? '0 : {W{b}};
        end

        // ---------------- transmit timing table ----------------
        for (int k = 0; k < 60; k++) begin
            if (tv[k].cyc == 0) begin
                bus.BitReverse = tv[k].brev;
                do_reset();
                if (k == 0) begin
                    chk("reset_parout", bus.ParOut, '0);
                    chk("reset_parvalid", bus.ParValid, '0);
                    chk("reset_locked", bus.Locked, '0);
                end
            end
            chk($sformatf("tx_load_brev%0d_cyc%0d", tv[k].brev, tv[k].cyc), bus.ParLoad, tv[k].exp_load);
            chk($sformatf("tx_ser_brev%0d_cyc%0d", tv[k].brev, tv[k].cyc), bus.SerOut, tv[k].exp_ser);
            @(posedge SerClk);
            @(negedge SerClk);
        end

        // ---------------- lock at a 3-bit offset ----------------
        bus.BitReverse = 1'b0;
        do_reset();
        push_zeros(3); push_sym(K_N); push_sym(D_AA); push_sym(D_AA);
        run_q();
        chk("lock_before", rec_lock[12], 1'b0);
        chk("lock_hunt_par", rec_par[12], 10'h000);
        chk("lock_after", rec_lock[13], 1'b1);
        chk("lock_valid0", rec_valid[13], 1'b1);
        chk("lock_par0", rec_par[13], K_N);
        chk("lock_valid1", rec_valid[23], 1'b1);
        chk("lock_par1", rec_par[23], D_AA);
        chk("lock_pulse_count", count_valid(0, 32), 2);
        chk("other_lanes_unlocked", bus.Locked[W-1:1], '0);

        // ---------------- misalignment, commas shifted by 4 ----------------
        do_reset();
        push_sym(K_N); push_sym(D_AA); push_zeros(4);
        push_sym(K_N); push_sym(K_N); push_sym(D_AA); push_sym(D_AA);
        run_q();
        chk("mis_lock_par", rec_par[10], K_N);
        chk("mis_d20", rec_par[20], D_AA);
        chk("mis_d30", rec_par[30], 10'h3C0);
        chk("mis_ignore_valid", rec_valid[34], 1'b0);
        chk("mis_ignore_par", rec_par[34], 10'h3C0);
        chk("mis_d40", rec_par[40], 10'h3C5);
        chk("mis_realign_valid", rec_valid[44], 1'b1);
        chk("mis_realign_par", rec_par[44], K_N);
        chk("mis_d54_valid", rec_valid[54], 1'b1);
        chk("mis_d54_par", rec_par[54], D_AA);
        chk("mis_pulse_count", count_valid(11, 63), 5);
        chk("mis_stays_locked", count_lock(10, 63), 54);

        // ---------------- comma timeout ----------------
        do_reset();
        push_sym(K_N);
        for (int k = 0; k < 5; k++) push_sym(D_AA);
        run_q();
        chk("tmo_d40_valid", rec_valid[40], 1'b1);
        chk("tmo_d40_par", rec_par[40], D_AA);
        chk("tmo_locked_49", rec_lock[49], 1'b1);
        chk("tmo_locked_50", rec_lock[50], 1'b0);
        chk("tmo_valid_50", rec_valid[50], 1'b0);
        chk("tmo_par_50", rec_par[50], 10'h000);
        chk("tmo_par_59", rec_par[59], 10'h000);
        chk("tmo_pulse_count", count_valid(11, 59), 3);

        // ---------------- bit reverse ----------------
        bus.BitReverse = 1'b1;
        do_reset();
        push_sym(K_N_REV); push_sym(D_AA_REV); push_sym(D_AA_REV);
        run_q();
        chk("rev_lock", rec_lock[10], 1'b1);
        chk("rev_valid0", rec_valid[10], 1'b1);
        chk("rev_par0", rec_par[10], K_N);
        chk("rev_valid1", rec_valid[20], 1'b1);
        chk("rev_par1", rec_par[20], D_AA);

        bus.BitReverse = 1'b0;
        do_reset();
        push_sym(K_N_REV); push_sym(D_AA_REV); push_sym(D_AA_REV);
        run_q();
        chk("norev_no_lock", count_lock(0, 29), 0);

        // ---------------- reset in the middle of a symbol ----------------
        do_reset();
        push_sym(K_N);
        for (int k = 0; k < 5; k++) q_bits.push_back(D_AA[k]);
        run_q();
        chk("midrst_locked_before", rec_lock[14], 1'b1);
        bus.SerIn[0] = 1'b0;
        Reset = 1'b1;
        @(posedge SerClk);
        #1;
        chk("midrst_locked", bus.Locked, '0);
        chk("midrst_valid", bus.ParValid, '0);
        chk("midrst_parout", bus.ParOut, '0);
        @(negedge SerClk);
        Reset = 1'b0;
        for (int k = 5; k < 10; k++) q_bits.push_back(D_AA[k]);
        push_zeros(15);
        run_q();
        chk("midrst_no_pulse", count_valid(0, 19), 0);
        chk("midrst_no_relock", count_lock(0, 19), 0);

`ifdef SERDES_LOOPBACK_EN
        // ---------------- loopback ----------------
        bus.BitReverse = 1'b0;
        bus.ParInVec   = {W{K_P}};
        bus.Loopback   = 1'b1;
        do_reset();
        repeat (40) @(posedge SerClk);
        @(negedge SerClk);
        chk("loop_locked", bus.Locked, {W{1'b1}});
        chk("loop_parout", bus.ParOut, {W{K_P}});
        bus.Loopback   = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lane_serdes_align.md
LANE_SERDES_ALIGN -- requirements
Module: lane_serdes_align

Interface
REQ-001 SHALL have parameter Width, default 16, number of lanes (1..32).
REQ-002 SHALL have parameter MisalignLimit, default 2, consecutive off-boundary commas that force realignment (1..15).
REQ-003 SHALL have parameter CommaTimeout, default 1024, symbols without an aligned comma before lock is dropped (2..65535).
REQ-004 SHALL have port SerClk  input  1  bit clock; one clock only; reset is synchronous and active-high.
REQ-005 SHALL have port Reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port BitReverse  input  1  1 = reverse each 10-bit symbol on both the parallel input and the parallel output; 0 = lsb-first.
REQ-007 SHALL have port ParInVec  input  Width*10  transmit symbols; lane i occupies bits i*10+9:i*10.
REQ-008 SHALL have port ParLoad  output  1  high in the cycle ParInVec is sampled.
REQ-009 SHALL have port SerOut  output  Width  serial transmit bit per lane.
REQ-010 SHALL have port SerIn  input  Width  serial receive bit per lane.
REQ-011 SHALL have port ParOut  output  Width*10  received aligned symbols.
REQ-012 SHALL have port ParValid  output  Width  per-lane one-cycle pulse when the ParOut lane updates.
REQ-013 SHALL have port Locked  output  Width  per-lane symbol lock.

Function
REQ-014 SHALL run a tx counter 0..9, wrapping; ParLoad = (count==9), combinational.
REQ-015 SHALL load all tx shifters from ParInVec on the edge where ParLoad is high; otherwise shift right with zero fill; SerOut[i] = shifter bit 0.
REQ-016 SHALL emit the first symbol's bit 0 on SerOut in cycle 10 after Reset deasserts.
REQ-017 SHALL shift SerIn[i] into the msb of a 10-bit rx window per lane every edge.
REQ-018 SHALL treat a window equal to NCOMMA or PCOMMA as a comma; detection is independent per lane.
REQ-019 SHALL implement a per-lane FSM with states HUNT and LOCKED.
REQ-020 HUNT, comma: ParOut lane <= window, ParValid pulse, Phase <= 0, go LOCKED.
REQ-021 LOCKED: Phase increments mod 10 each edge; at Phase==9, ParOut lane <= window and ParValid pulses.
REQ-022 LOCKED, comma at Phase==9: misalign count <= 0 and timeout count <= 0.
REQ-023 LOCKED, comma at Phase!=9: misalign count increments; when it reaches MisalignLimit, realign as in REQ-020 (stay LOCKED, count <= 0).
REQ-024 LOCKED: a timeout counter increments per delivered symbol; at CommaTimeout go HUNT and clear Locked.
REQ-025 In HUNT, ParOut lane SHALL hold 0 and ParValid SHALL be 0.
REQ-026 Realignment and timeout in the same cycle: realignment wins.
REQ-027 Locked[i] SHALL be high exactly while lane i is in LOCKED.

Reset
REQ-028 Reset SHALL clear the tx counter to 0, tx shifters, SerOut, rx windows, ParOut, ParValid, Locked, Phase, and all counters, and force HUNT.
REQ-029 Reset asserted mid-symbol SHALL abort that symbol; no partial ParValid.

Configuration
REQ-030 SERDES_LOOPBACK_EN defined: SHALL add input Loopback (1); when high, each rx window takes SerOut[i] instead of SerIn[i]. Undefined: no port, SerIn only.

Structure
REQ-031 NCOMMA, PCOMMA, the FSM state typedef and the symbol width (10) SHALL live in the shared serdes package.
REQ-032 The per-lane rx aligner SHALL be sub-module lane_rx_align, instantiated Width times.

Verification
REQ-033 Reset release, ParInVec all lanes 10'h17C -> ParLoad in cycles 9, 19, ...; SerOut lane 0 bits 0,0,1,1,1,1,1,0,1,0 from cycle 10.
REQ-034 SerIn lane 0 fed NCOMMA then 10'h0AA, lsb-first, at a 3-bit offset -> Locked[0] high, ParOut lane 0 = NCOMMA then 10'h0AA, ParValid 10 cycles apart.
REQ-035 Locked lane, commas shifted 4 bits, MisalignLimit=2 -> first shifted comma ignored, second realigns; ParValid spacing breaks once.
REQ-036 CommaTimeout=4, data with no commas after lock -> Locked drops after the 4th symbol; ParOut returns to 0.
REQ-037 BitReverse=1 with a reversed comma on SerIn -> lock; ParOut presents the reversed window.
REQ-038 SERDES_LOOPBACK_EN, Loopback=1, ParInVec=PCOMMA -> all lanes Locked; ParOut = PCOMMA.
